tlb_maint_ctrl: RTL and testbench

Sequencer for privileged TLB maintenance ops (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued from the M2 stage. Takes one op at a time over a valid/ready handshake and borrows the TLB search port from the LSU through a req/gnt pair. Drives the TLB write, read and invalidate interfaces, then returns a single done pulse with results for the CSR unit. Sits between the pipeline M2 stage and the mmu/tlb block.

---
 rtl/tlb_maint_ctrl_pkg.sv | 24 ++
 rtl/tlb_maint_ctrl_fill_ptr.sv | 33 +++
 rtl/tlb_maint_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared encodings for the TLB maintenance sequencer: op codes, FSM states
// and the largest INVTLB op that is legal to execute.
package tlb_maint_ctrl_pkg;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SRCH_REQ = 3'd1,
        ST_WRITE    = 3'd2,
        ST_INV      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } tlb_state_e;

    localparam logic [4:0] INVTLB_MAX_OP = 5'd6;

endpackage

// File: rtl/tlb_maint_ctrl_fill_ptr.sv
// Free-running replacement pointer for TLBFILL; wraps at the last entry.
// Kept behind a plain ptr_o interface so a pseudo-random source can drop in.
module tlb_maint_ctrl_fill_ptr #(
    parameter int TLB_ENTRY_NUM = 32,
    parameter int INDEX_LEN     = $clog2(TLB_ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [INDEX_LEN-1:0] ptr_o
);

    logic [INDEX_LEN-1:0] ptr_q;
    logic [INDEX_LEN-1:0] ptr_d;

    always_comb begin
        if (ptr_q == INDEX_LEN'(TLB_ENTRY_NUM - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q + INDEX_LEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Sequencer for privileged TLB maintenance ops issued from M2; borrows the
// LSU search port, drives TLB write/read/invalidate and reports one done pulse.
//
// state    | meaning
// IDLE     | waiting for an op, op_ready_o high
// SRCH_REQ | requesting the shared search port, result sampled on gnt
// WRITE    | single-cycle TLB write (WR index or fill pointer)
// INV      | single-cycle invalidate pulse
// DRAIN    | idle cycle so later lookups see the updated array
// DONE     | done_o pulse with results, back to IDLE
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
#(
    parameter  int TLB_ENTRY_NUM = 32,
    localparam int INDEX_LEN     = $clog2(TLB_ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [2:0]           op_i,
    input  logic [4:0]           inv_op_i,
    input  logic                 flush_i,
    input  logic [31:0]          tlbehi_i,
    input  logic [31:0]          tlbidx_i,
    input  logic [9:0]           asid_i,
    input  logic [9:0]           invtlb_asid_i,
    input  logic [18:0]          invtlb_vpn_i,
    output logic                 port_req_o,
    input  logic                 port_gnt_i,
    output logic [18:0]          srch_vppn_o,
    output logic [9:0]           srch_asid_o,
    input  logic                 srch_found_i,
    input  logic [INDEX_LEN-1:0] srch_index_i,
    output logic [INDEX_LEN-1:0] rd_index_o,
    output logic                 we_o,
    output logic [INDEX_LEN-1:0] w_index_o,
    output logic                 inv_en_o,
    output logic [4:0]           inv_op_o,
    output logic [9:0]           inv_asid_o,
    output logic [18:0]          inv_vpn_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 srch_hit_o,
    output logic [INDEX_LEN-1:0] srch_index_o,
    output logic                 rd_upd_o,
    output logic                 ine_o
);

    tlb_state_e           state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [INDEX_LEN-1:0] idx_q, idx_d;
    logic [18:0]          vppn_q, vppn_d;
    logic [4:0]           inv_op_q, inv_op_d;
    logic [9:0]           inv_asid_q, inv_asid_d;
    logic [18:0]          inv_vpn_q, inv_vpn_d;
    logic                 srch_hit_q, srch_hit_d;
    logic [INDEX_LEN-1:0] srch_index_q, srch_index_d;
    logic                 ine_q, ine_d;
    logic                 accept;
    logic [INDEX_LEN-1:0] fill_ptr;
    logic                 unused_csr_bits;

    assign unused_csr_bits = ^{tlbidx_i[31:INDEX_LEN], tlbehi_i[12:0]};

    tlb_maint_ctrl_fill_ptr #(
        .TLB_ENTRY_NUM (TLB_ENTRY_NUM),
        .INDEX_LEN     (INDEX_LEN)
    ) u_fill_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .ptr_o (fill_ptr)
    );

    assign accept = (state_q == ST_IDLE) & op_valid_i & ~flush_i;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        idx_d        = idx_q;
        vppn_d       = vppn_q;
        inv_op_d     = inv_op_q;
        inv_asid_d   = inv_asid_q;
        inv_vpn_d    = inv_vpn_q;
        srch_hit_d   = srch_hit_q;
        srch_index_d = srch_index_q;
        ine_d        = ine_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d       = op_i;
                    idx_d      = tlbidx_i[INDEX_LEN-1:0];
                    vppn_d     = tlbehi_i[31:13];
                    inv_op_d   = inv_op_i;
                    inv_asid_d = invtlb_asid_i;
                    inv_vpn_d  = invtlb_vpn_i;
                    case (op_i)
                        TLBOP_SRCH: state_d = ST_SRCH_REQ;
                        TLBOP_WR,
                        TLBOP_FILL: state_d = ST_WRITE;
                        TLBOP_INV: begin
                            if (inv_op_i > INVTLB_MAX_OP) begin
                                state_d = ST_DONE;
                                ine_d   = 1'b1;
                            end else begin
                                state_d = ST_INV;
                            end
                        end
                        // RD and reserved codes complete immediately
                        default: begin
                            state_d = ST_DONE;
                            ine_d   = 1'b0;
                        end
                    endcase
                end
            end
            ST_SRCH_REQ: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (port_gnt_i) begin
                    srch_hit_d   = srch_found_i;
                    srch_index_d = srch_index_i;
                    ine_d        = 1'b0;
                    state_d      = ST_DONE;
                end
            end
            ST_WRITE, ST_INV: state_d = ST_DRAIN;
            ST_DRAIN: begin
                ine_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            idx_q        <= '0;
            vppn_q       <= '0;
            inv_op_q     <= '0;
            inv_asid_q   <= '0;
            inv_vpn_q    <= '0;
            srch_hit_q   <= 1'b0;
            srch_index_q <= '0;
            ine_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            vppn_q       <= vppn_d;
            inv_op_q     <= inv_op_d;
            inv_asid_q   <= inv_asid_d;
            inv_vpn_q    <= inv_vpn_d;
            srch_hit_q   <= srch_hit_d;
            srch_index_q <= srch_index_d;
            ine_q        <= ine_d;
        end
    end

    // A flush in SRCH_REQ wins over a same-cycle grant, so the request drops at once
    assign port_req_o   = (state_q == ST_SRCH_REQ) & ~flush_i;
    assign op_ready_o   = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign we_o         = (state_q == ST_WRITE);
    assign inv_en_o     = (state_q == ST_INV);
    assign done_o       = (state_q == ST_DONE);
    assign rd_upd_o     = (state_q == ST_DONE) & (op_q == TLBOP_RD);
    assign w_index_o    = (op_q == TLBOP_FILL) ? fill_ptr : idx_q;
    assign rd_index_o   = idx_q;
    assign srch_vppn_o  = vppn_q;
    assign srch_asid_o  = asid_i;
    assign inv_op_o     = inv_op_q;
    assign inv_asid_o   = inv_asid_q;
    assign inv_vpn_o    = inv_vpn_q;
    assign srch_hit_o   = srch_hit_q;
    assign srch_index_o = srch_index_q;
    assign ine_o        = ine_q;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: directed ops push expected results,
// a negedge monitor pops and checks them on every done_o.
module tb_tlb_maint_ctrl;

    localparam int N = 32;
    localparam int IL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid_i = 1'b0;
    logic          op_ready_o;
    logic [2:0]    op_i = '0;
    logic [4:0]    inv_op_i = '0;
    logic          flush_i = 1'b0;
    logic [31:0]   tlbehi_i = '0;
    logic [31:0]   tlbidx_i = '0;
    logic [9:0]    asid_i = '0;
    logic [9:0]    invtlb_asid_i = '0;
    logic [18:0]   invtlb_vpn_i = '0;
    logic          port_req_o;
    logic          port_gnt_i = 1'b1;
    logic [18:0]   srch_vppn_o;
    logic [9:0]    srch_asid_o;
    logic          srch_found_i = 1'b0;
    logic [IL-1:0] srch_index_i = '0;
    logic [IL-1:0] rd_index_o;
    logic          we_o;
    logic [IL-1:0] w_index_o;
    logic          inv_en_o;
    logic [4:0]    inv_op_o;
    logic [9:0]    inv_asid_o;
    logic [18:0]   inv_vpn_o;
    logic          busy_o;
    logic          done_o;
    logic          srch_hit_o;
    logic [IL-1:0] srch_index_o;
    logic          rd_upd_o;
    logic          ine_o;

    tlb_maint_ctrl #(.TLB_ENTRY_NUM(N)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_i(op_i), .inv_op_i(inv_op_i), .flush_i(flush_i), .tlbehi_i(tlbehi_i),
        .tlbidx_i(tlbidx_i), .asid_i(asid_i), .invtlb_asid_i(invtlb_asid_i),
        .invtlb_vpn_i(invtlb_vpn_i), .port_req_o(port_req_o), .port_gnt_i(port_gnt_i),
        .srch_vppn_o(srch_vppn_o), .srch_asid_o(srch_asid_o), .srch_found_i(srch_found_i),
        .srch_index_i(srch_index_i), .rd_index_o(rd_index_o), .we_o(we_o),
        .w_index_o(w_index_o), .inv_en_o(inv_en_o), .inv_op_o(inv_op_o),
        .inv_asid_o(inv_asid_o), .inv_vpn_o(inv_vpn_o), .busy_o(busy_o), .done_o(done_o),
        .srch_hit_o(srch_hit_o), .srch_index_o(srch_index_o), .rd_upd_o(rd_upd_o),
        .ine_o(ine_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op; int lat; int done_cyc;
        int hit; int sidx; int vppn; int asid;
        int rd_idx; int ine;
        int n_we; int w_idx;
        int n_inv; int iop; int iasid; int ivpn;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rst_rel = 0;
    int   we_seen = 0, last_w = 0;
    int   inv_seen = 0, last_iop = 0, last_iasid = 0, last_ivpn = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic exp_t mk(int op, int lat);
        exp_t e;
        e = '{default: 0};
        e.op = op;
        e.lat = lat;
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            we_seen = 0;
            inv_seen = 0;
        end else begin
            if (we_o) begin
                we_seen++;
                last_w = int'(w_index_o);
            end
            if (inv_en_o) begin
                inv_seen++;
                last_iop = int'(inv_op_o);
                last_iasid = int'(inv_asid_o);
                last_ivpn = int'(inv_vpn_o);
            end
            if (port_req_o && port_gnt_i && exp_q.size() > 0) begin
                chk("srch_vppn", int'(srch_vppn_o), exp_q[0].vppn);
                chk("srch_asid", int'(srch_asid_o), exp_q[0].asid);
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done_o=1 expected no done (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("rd_upd", int'(rd_upd_o), (e.op == 1) ? 1 : 0);
                    chk("ine", int'(ine_o), e.ine);
                    chk("we_count", we_seen, e.n_we);
                    if (e.n_we > 0) chk("w_index", last_w, e.w_idx);
                    chk("inv_count", inv_seen, e.n_inv);
                    if (e.n_inv > 0) begin
                        chk("inv_op", last_iop, e.iop);
                        chk("inv_asid", last_iasid, e.iasid);
                        chk("inv_vpn", last_ivpn, e.ivpn);
                    end
                    if (e.op == 0) begin
                        chk("srch_hit", int'(srch_hit_o), e.hit);
                        if (e.hit != 0) chk("srch_index", int'(srch_index_o), e.sidx);
                    end
                    if (e.op == 1) chk("rd_index", int'(rd_index_o), e.rd_idx);
                end
                we_seen = 0;
                inv_seen = 0;
            end
        end
    end

    // Called and returning at posedge+1
    task automatic wait_idle();
        int n = 0;
        while (!op_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!op_ready_o) chk("op_ready_wait", int'(op_ready_o), 1);
    endtask

    task automatic send(input exp_t e_in, input bit push);
        exp_t e;
        e = e_in;
        wait_idle();
        op_valid_i = 1'b1;
        e.done_cyc = cyc + e.lat;
        if (e.op == 3) e.w_idx = (cyc + 1 - rst_rel) % N;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        op_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(op_ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_port_req", int'(port_req_o), 0);
        chk("rst_we", int'(we_o), 0);
        chk("rst_inv_en", int'(inv_en_o), 0);
        chk("rst_srch_hit", int'(srch_hit_o), 0);
        chk("rst_ine", int'(ine_o), 0);
        chk("rst_rd_index", int'(rd_index_o), 0);
        chk("rst_inv_op", int'(inv_op_o), 0);
        rst_n = 1'b1;
        rst_rel = cyc;
        @(posedge clk); #1;

        // SRCH hit, immediate grant; CSR change after accept must not matter
        port_gnt_i = 1'b1; srch_found_i = 1'b1; srch_index_i = 5'd5;
        tlbehi_i = 32'hABCD_E000; asid_i = 10'h2A; op_i = 3'd0;
        e = mk(0, 2); e.hit = 1; e.sidx = 5; e.vppn = 19'h55E6F; e.asid = 10'h2A;
        send(e, 1);
        tlbehi_i = 32'h0;

        // SRCH miss, grant held off for two cycles
        wait_idle();
        port_gnt_i = 1'b0; srch_found_i = 1'b0; srch_index_i = 5'd9;
        tlbehi_i = 32'h0000_2000; asid_i = 10'h3FF; op_i = 3'd0;
        e = mk(0, 4); e.hit = 0; e.vppn = 1; e.asid = 10'h3FF;
        send(e, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        port_gnt_i = 1'b1;

        // SRCH flushed while waiting for grant
        wait_idle();
        port_gnt_i = 1'b0; op_i = 3'd0;
        send(mk(0, 0), 0);
        chk("flush_req_c1", int'(port_req_o), 1);
        @(posedge clk); #1;
        chk("flush_req_c2", int'(port_req_o), 1);
        @(posedge clk); #1;
        flush_i = 1'b1;
        #1;
        chk("flush_req_drop", int'(port_req_o), 0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_ready", int'(op_ready_o), 1);
        chk("flush_busy", int'(busy_o), 0);
        @(posedge clk); #1;
        port_gnt_i = 1'b1;

        // Flush in IDLE blocks accept
        op_i = 3'd1; op_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        op_valid_i = 1'b0; flush_i = 1'b0;
        chk("idle_flush_busy", int'(busy_o), 0);

        // RD
        tlbidx_i = 32'hFFFF_FF77; op_i = 3'd1;
        e = mk(1, 1); e.rd_idx = 23;
        send(e, 1);

        // WR with index changed after accept
        tlbidx_i = 32'd9; op_i = 3'd2;
        e = mk(2, 3); e.n_we = 1; e.w_idx = 9;
        send(e, 1);
        tlbidx_i = 32'd3;

        // INVTLB op 5, 7 (illegal), 6 (largest legal)
        op_i = 3'd4; inv_op_i = 5'd5; invtlb_asid_i = 10'h12; invtlb_vpn_i = 19'h1234;
        e = mk(4, 3); e.n_inv = 1; e.iop = 5; e.iasid = 10'h12; e.ivpn = 19'h1234;
        send(e, 1);
        inv_op_i = 5'd7;
        e = mk(4, 1); e.ine = 1;
        send(e, 1);
        inv_op_i = 5'd6; invtlb_asid_i = 10'h3; invtlb_vpn_i = 19'h7FFFF;
        e = mk(4, 3); e.n_inv = 1; e.iop = 6; e.iasid = 10'h3; e.ivpn = 19'h7FFFF;
        send(e, 1);

        // Reserved op code
        op_i = 3'd6;
        send(mk(6, 1), 1);

        // Reset while in WRITE
        tlbidx_i = 32'd4; op_i = 3'd2;
        send(mk(2, 3), 0);
        chk("rst_mid_we_before", int'(we_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_after", int'(we_o), 0);
        chk("rst_mid_busy", int'(busy_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rst_rel = cyc;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_idle", int'(busy_o), 0);

        // Back-to-back FILLs, long enough to cross the pointer wrap
        op_i = 3'd3;
        for (int i = 0; i < 10; i++) begin
            e = mk(3, 3); e.n_we = 1;
            send(e, 1);
        end

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("queue_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
